// File: rtl/cp0_trap_seq.sv
// cp0_trap_seq: trap entry/exit sequencer between the control unit and the
// CP0 register file. Accepts one request in IDLE, then drives the CP0 write
// port through EPC/Cause/Status (entry) or Status (eret), one write per cycle,
// and finishes with a single-cycle PC redirect. Status and EPC are shadowed
// here so that the redirect target and the exception masks are always local.
module cp0_trap_seq #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_000F,
  parameter int          STAT_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        eret_req,
  input  logic        mtc0_req,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [31:0] cur_pc,
  output logic        busy,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [31:0] status_o,
  output logic [31:0] epc_o
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_EPC   = 3'd1,
    S_W_CAUSE = 3'd2,
    S_W_STAT  = 3'd3,
    S_T_REDIR = 3'd4,
    S_E_STAT  = 3'd5,
    S_E_REDIR = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [31:0] r_epc_l;
  logic [4:0]  r_code;

  logic        w_exc_req;
  logic        w_exc_en;
  logic [4:0]  w_exc_code;
  logic        w_accept;

  // Fixed-priority exception pick; only the top requester is considered, so a
  // masked high-priority source never lets a lower one through.
  always_comb begin
    w_exc_req  = break_req | syscall_req | teq_req;
    w_exc_en   = 1'b0;
    w_exc_code = 5'd0;
    if (break_req) begin
      w_exc_en   = r_status[0] & r_status[2];
      w_exc_code = 5'd9;
    end else if (syscall_req) begin
      w_exc_en   = r_status[0] & r_status[1];
      w_exc_code = 5'd8;
    end else if (teq_req) begin
      w_exc_en   = r_status[0] & r_status[3];
      w_exc_code = 5'd13;
    end else begin
      w_exc_en   = 1'b0;
      w_exc_code = 5'd0;
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_exc_en;

  // Next-state and per-state drive of the stall, CP0 write port and redirect.
  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    cp0_we      = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wdata   = 32'd0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_exc_req) begin
          if (w_exc_en) begin
            busy   = 1'b1;
            w_next = S_W_EPC;
          end else begin
            w_next = S_IDLE;
          end
        end else if (eret_req) begin
          busy   = 1'b1;
          w_next = S_E_STAT;
        end else if (mtc0_req) begin
          cp0_we    = 1'b1;
          cp0_waddr = mtc0_addr;
          cp0_wdata = mtc0_data;
          w_next    = S_IDLE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_W_EPC: begin
        busy      = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_EPC;
        cp0_wdata = r_epc_l;
        w_next    = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        busy      = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_CAUSE;
        cp0_wdata = {25'd0, r_code, 2'b00};
        w_next    = S_W_STAT;
      end
      S_W_STAT: begin
        busy      = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_STATUS;
        cp0_wdata = r_status << STAT_SHIFT;
        w_next    = S_T_REDIR;
      end
      S_T_REDIR: begin
        busy        = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = EXC_VECTOR;
        w_next      = S_IDLE;
      end
      S_E_STAT: begin
        busy      = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_STATUS;
        cp0_wdata = r_status >> STAT_SHIFT;
        w_next    = S_E_REDIR;
      end
      S_E_REDIR: begin
        busy        = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = r_epc;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register plus request latch; reset drops any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_epc_l <= 32'd0;
      r_code  <= 5'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_epc_l <= cur_pc;
        r_code  <= w_exc_code;
      end else begin
        r_epc_l <= r_epc_l;
        r_code  <= r_code;
      end
    end
  end

  // Shadows follow whatever this block puts on the CP0 write port, which
  // covers sequencer writes and mtc0 pass-through alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= STATUS_RST;
      r_epc    <= 32'd0;
    end else begin
      if (cp0_we && (cp0_waddr == ADDR_STATUS)) begin
        r_status <= cp0_wdata;
      end else begin
        r_status <= r_status;
      end
      if (cp0_we && (cp0_waddr == ADDR_EPC)) begin
        r_epc <= cp0_wdata;
      end else begin
        r_epc <= r_epc;
      end
    end
  end

  assign status_o = r_status;
  assign epc_o    = r_epc;

endmodule
